// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// FSM states, funct3 encodings and the store-buffer entry.
package dmem_ctrl_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic [2:0]             funct3;
    logic [DMEM_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer.sv
// Committed-store FIFO with an address-match probe
// across all live entries, used to hold back loads.
module dmem_store_buffer
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  sb_entry_t              push_entry,
  input  logic [DMEM_ADDR_W-1:0] lk_addr,
  output sb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic                   hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t       ent_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  // Occupancy, handshake qualification and pointer advance
  always_comb begin
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    head     = ent_q[rd_ptr_q];
  end

  // Full-address compare against every live entry
  always_comb begin : hit_scan
    logic [PW-1:0] off;
    off = '0;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if (({1'b0, off} < cnt_q) &&
          (ent_q[i].addr == lk_addr))
        hit = 1'b1;
    end
  end

  // Entry storage; liveness comes from the pointers
  always_ff @(posedge clk) begin
    if (do_push) ent_q[wr_ptr_q] <= push_entry;
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-port data-memory sequencer: tagged loads
// arbitrated against a buffered stream of committed stores.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W          = DMEM_ADDR_W,
  parameter int DATA_W          = DMEM_DATA_W,
  parameter int TAG_W           = 4,
  parameter int SB_DEPTH        = 4,
  parameter int MAX_LOAD_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_funct3,
  input  logic [TAG_W-1:0]  ld_tag,
  output logic              ld_rsp_valid,
  input  logic              ld_rsp_ready,
  output logic [DATA_W-1:0] ld_rsp_data,
  output logic [TAG_W-1:0]  ld_rsp_tag,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_funct3,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_load_done,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sb_empty
);

  localparam int STK_W = $clog2(MAX_LOAD_STREAK + 1);

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              ld_en_q, ld_en_d;
  logic              wr_en_q, wr_en_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STK_W-1:0]  streak_q, streak_d;

  sb_entry_t st_entry, sb_head;
  logic      sb_full, addr_hit, force_store;
  logic      ld_acc, st_push, drain;

  dmem_store_buffer #(
    .DEPTH(SB_DEPTH)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .push      (st_push),
    .pop       (drain),
    .push_entry(st_entry),
    .lk_addr   (ld_addr),
    .head      (sb_head),
    .full      (sb_full),
    .empty     (sb_empty),
    .hit       (addr_hit)
  );

  // Port arbitration: loads win unless a store must go
  always_comb begin
    st_entry    = '{addr: st_addr, funct3: st_funct3,
                    data: st_data};
    force_store = (streak_q == STK_W'(MAX_LOAD_STREAK))
                  && !sb_empty;
    ld_ready    = (state_q == S_IDLE) && !flush
                  && !addr_hit && !sb_full && !force_store;
    ld_acc      = ld_valid && ld_ready;
    st_ready    = !sb_full;
    st_push     = st_valid && !sb_full;
    // a stalled response leaves the port free for stores
    drain       = !sb_empty &&
                  (((state_q == S_IDLE) && !ld_acc) ||
                   ((state_q == S_RESP) && !ld_rsp_ready));
  end

  // Load FSM, memory command and streak next-state
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    ld_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    streak_d    = streak_q;
    unique case (state_q)
      S_IDLE: begin
        if (ld_acc) begin
          state_d   = S_LOAD;
          ld_en_d   = 1'b1;
          addr_d    = ld_addr;
          f3_d      = ld_funct3;
          rsp_tag_d = ld_tag;
        end
      end
      S_LOAD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_RESP;
          rsp_data_d  = mem_rdata;
          rsp_valid_d = 1'b1;
        end
      end
      S_RESP: begin
        if (flush || ld_rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (drain) begin
      wr_en_d = 1'b1;
      addr_d  = sb_head.addr;
      f3_d    = sb_head.funct3;
      wdata_d = sb_head.data;
    end
    if (drain || sb_empty)
      streak_d = '0;
    else if (ld_acc)
      streak_d = streak_q + STK_W'(1);
  end

  // State and registered memory/response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      ld_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      ld_en_q     <= ld_en_d;
      wr_en_q     <= wr_en_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      streak_q    <= streak_d;
    end
  end

  assign ld_rsp_valid  = rsp_valid_q;
  assign ld_rsp_data   = rsp_data_q;
  assign ld_rsp_tag    = rsp_tag_q;
  assign mem_load_done = ld_en_q;
  assign mem_write     = wr_en_q;
  assign mem_funct3    = f3_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a
// small combinational-read memory model.
module tb_dmem_access_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic [3:0]  ld_tag;
  logic        ld_rsp_valid, ld_rsp_ready;
  logic [31:0] ld_rsp_data;
  logic [3:0]  ld_rsp_tag;
  logic        st_valid, st_ready;
  logic [31:0] st_addr;
  logic [2:0]  st_funct3;
  logic [31:0] st_data;
  logic        mem_load_done, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        sb_empty;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_funct3    (ld_funct3),
    .ld_tag       (ld_tag),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_ready (ld_rsp_ready),
    .ld_rsp_data  (ld_rsp_data),
    .ld_rsp_tag   (ld_rsp_tag),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_funct3    (st_funct3),
    .st_data      (st_data),
    .mem_load_done(mem_load_done),
    .mem_write    (mem_write),
    .mem_funct3   (mem_funct3),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .sb_empty     (sb_empty)
  );

  // memory model: word i initialised to i+3
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i + 3);
    end else if (mem_write) begin
      mem[6'(mem_addr)] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[6'(mem_addr)];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // load and store never share the port in one cycle
  always @(negedge clk) begin
    if (reset) begin
      nvec++;
      assert (!(mem_load_done && mem_write)) else begin
        nerr++;
        $error("FAIL excl: observed ld=%0b wr=%0b expected not both",
               mem_load_done, mem_write);
      end
    end
  end

  int  pushed, wr_idx, grants;
  logic hs, saw_full, seen_wr;

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    ld_valid = 1'b0; ld_addr = '0;
    ld_funct3 = F3_LW; ld_tag = '0;
    ld_rsp_ready = 1'b1;
    st_valid = 1'b0; st_addr = '0;
    st_funct3 = F3_SW; st_data = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem", {mem_load_done, mem_write,
        mem_funct3, mem_addr}, 64'h0);
    chk("rst_rsp", {ld_rsp_valid, ld_rsp_tag,
        ld_rsp_data}, 64'h0);
    chk("rst_sbe", sb_empty, 1);
    reset = 1'b1;
    @(negedge clk);

    // 1: LW addr 5 tag 3
    ld_valid = 1'b1; ld_addr = 5; ld_tag = 3;
    #1 chk("t1_ready", ld_ready, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("t1_lddone", mem_load_done, 1);
    chk("t1_addr", mem_addr, 5);
    chk("t1_f3", mem_funct3, F3_LW);
    chk("t1_novld", ld_rsp_valid, 0);
    @(negedge clk);
    chk("t1_lddone0", mem_load_done, 0);
    chk("t1_vld", ld_rsp_valid, 1);
    chk("t1_data", ld_rsp_data, 8);
    chk("t1_tag", ld_rsp_tag, 3);
    @(negedge clk);
    chk("t1_vld0", ld_rsp_valid, 0);

    // 2: fill store buffer behind continuous loads
    ld_valid = 1'b1; ld_addr = 40; ld_tag = 1;
    st_valid = 1'b1; st_addr = 20; st_data = 32'hA0;
    pushed = 0; wr_idx = 0; saw_full = 1'b0;
    #1;
    for (int c = 0; c < 60 && wr_idx < 5; c++) begin
      hs = st_valid && st_ready;
      if (st_valid && !st_ready) begin
        saw_full = 1'b1;
        chk("t2_full_cnt", pushed, 4);
        chk("t2_full_ldblk", ld_ready, 0);
      end
      @(negedge clk);
      if (mem_write) begin
        chk("t2_ord_addr", mem_addr, 20 + wr_idx);
        chk("t2_ord_data", mem_wdata, 32'hA0 + wr_idx);
        wr_idx++;
      end
      if (hs) begin
        pushed++;
        if (pushed == 5) begin
          st_valid = 1'b0;
          ld_valid = 1'b0;
        end else begin
          st_addr = 32'(20 + pushed);
          st_data = 32'(32'hA0 + pushed);
        end
      end
      #1;
    end
    chk("t2_nwrites", wr_idx, 5);
    chk("t2_saw_full", saw_full, 1);
    ld_valid = 1'b0; st_valid = 1'b0;
    repeat (4) @(negedge clk);

    // 3: load to an address with a pending store
    ld_valid = 1'b1; ld_addr = 30; ld_tag = 1;
    @(negedge clk);
    ld_addr = 10; ld_tag = 7;
    st_valid = 1'b1; st_addr = 10; st_data = 32'h55;
    #1 chk("t3_ld_busy", ld_ready, 0);
    @(negedge clk);
    st_valid = 1'b0;
    chk("t3_sb_ne", sb_empty, 0);
    chk("t3_r1_vld", ld_rsp_valid, 1);
    chk("t3_r1_data", ld_rsp_data, 33);
    @(negedge clk);
    chk("t3_hit_blk", ld_ready, 0);
    chk("t3_nowr", mem_write, 0);
    @(negedge clk);
    chk("t3_wr", mem_write, 1);
    chk("t3_wr_addr", mem_addr, 10);
    chk("t3_ld_ok", ld_ready, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("t3_lddone", mem_load_done, 1);
    chk("t3_ldaddr", mem_addr, 10);
    @(negedge clk);
    chk("t3_vld", ld_rsp_valid, 1);
    chk("t3_data", ld_rsp_data, 32'h55);
    chk("t3_tag", ld_rsp_tag, 7);
    @(negedge clk);

    // 4: load streak starves one store for 4 grants
    ld_valid = 1'b1; ld_addr = 50; ld_tag = 2;
    st_valid = 1'b1; st_addr = 60; st_data = 32'h77;
    @(negedge clk);
    st_valid = 1'b0;
    grants = 0; seen_wr = 1'b0;
    for (int c = 0; c < 60 && !seen_wr; c++) begin
      if (mem_write) begin
        seen_wr = 1'b1;
        ld_valid = 1'b0;
      end else begin
        if (ld_valid && ld_ready) grants++;
        @(negedge clk);
      end
    end
    chk("t4_drained", seen_wr, 1);
    chk("t4_grants", grants, 4);
    chk("t4_addr", mem_addr, 60);
    chk("t4_data", mem_wdata, 32'h77);
    ld_valid = 1'b0;
    @(negedge clk);

    // 5: flush in S_LOAD
    ld_valid = 1'b1; ld_addr = 7; ld_tag = 2;
    @(negedge clk);
    ld_valid = 1'b0; flush = 1'b1;
    chk("t5_lddone", mem_load_done, 1);
    @(negedge clk);
    flush = 1'b0;
    ld_valid = 1'b1; ld_addr = 8; ld_tag = 4;
    #1 chk("t5_ready", ld_ready, 1);
    chk("t5_novld1", ld_rsp_valid, 0);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("t5_novld2", ld_rsp_valid, 0);
    chk("t5_addr", mem_addr, 8);
    @(negedge clk);
    chk("t5_vld", ld_rsp_valid, 1);
    chk("t5_data", ld_rsp_data, 11);
    chk("t5_tag", ld_rsp_tag, 4);
    @(negedge clk);

    // 6: reset with stores buffered and load in S_RESP
    ld_rsp_ready = 1'b0;
    ld_valid = 1'b1; ld_addr = 3; ld_tag = 5;
    st_valid = 1'b1; st_addr = 70; st_data = 32'hE0;
    @(negedge clk);
    ld_valid = 1'b0;
    st_addr = 71; st_data = 32'hE1;
    @(negedge clk);
    st_valid = 1'b0;
    chk("t6_pre_vld", ld_rsp_valid, 1);
    chk("t6_pre_sb", sb_empty, 0);
    reset = 1'b0;
    #1;
    chk("t6_mem0", {mem_load_done, mem_write,
        mem_funct3, mem_addr}, 64'h0);
    chk("t6_wd0", mem_wdata, 0);
    chk("t6_rsp0", {ld_rsp_valid, ld_rsp_tag,
        ld_rsp_data}, 64'h0);
    chk("t6_sbe", sb_empty, 1);
    @(negedge clk);
    ld_rsp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_nowr", mem_write, 0);
    end
    chk("t6_sbe2", sb_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
